// File: rtl/obf_key_pkg.sv
// Shared types for the camouflaged-gate key configuration controller.
package obf_key_pkg;

  typedef enum logic [1:0] {
    CELL_PASS = 2'b00,
    CELL_INV  = 2'b01,
    CELL_ONE  = 2'b10,
    CELL_ZERO = 2'b11
  } cell_mode_e;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_COMMIT,
    LOCKED
  } state_e;

  // Words needed to carry a key of key_w bits.
  function automatic int unsigned nwords(input int unsigned key_w, input int unsigned word_w);
    return (key_w + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/obf_key_cfg_ctrl_if.sv
// Key-word stream (valid/ready) between a key source and obf_key_cfg_ctrl.
interface obf_key_cfg_ctrl_if #(
  parameter int unsigned WORD_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              in_parity;

  modport master (output in_valid, output in_data, output in_parity, input in_ready);
  modport slave  (input in_valid, input in_data, input in_parity, output in_ready);
endinterface

// File: rtl/obf_key_shadow.sv
// Word-addressed shadow key register; bits of the top word beyond KEY_W are dropped.
module obf_key_shadow #(
  parameter int unsigned KEY_W  = 10,
  parameter int unsigned WORD_W = 4,
  parameter int unsigned IDX_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [WORD_W-1:0] wr_data,
  output logic [KEY_W-1:0]  shadow
);

  logic [KEY_W-1:0] shadow_d;

  // Each key bit belongs to exactly one word slot; only existing bits are generated.
  for (genvar b = 0; b < KEY_W; b++) begin : g_bit
    assign shadow_d[b] = clr ? 1'b0 :
                         (wr_en && (wr_idx == IDX_W'(b / WORD_W))) ? wr_data[b % WORD_W] :
                         shadow[b];
  end

  always_ff @(posedge clk) begin
    if (rst) shadow <= '0;
    else     shadow <= shadow_d;
  end

endmodule

// File: rtl/obf_key_cfg_ctrl.sv
// Stages a camouflage key from a word stream and applies it atomically on commit, with optional lock.
// Optional word parity checking is enabled by defining OBF_KEY_PARITY_EN.
module obf_key_cfg_ctrl
  import obf_key_pkg::*;
#(
  parameter  int unsigned NUM_CELLS = 5,
  parameter  int unsigned WORD_W    = 4,
  localparam int unsigned KEY_W     = 2 * NUM_CELLS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_start,
  input  logic               cfg_abort,
  input  logic               commit_req,
  input  logic               lock_req,
  obf_key_cfg_ctrl_if.slave  bus,
  output logic [KEY_W-1:0]   key_out,
  output logic               key_valid,
  output logic               busy,
  output logic               locked,
  output logic               err
);

  localparam int unsigned     NWORDS   = nwords(KEY_W, WORD_W);
  localparam int unsigned     IDX_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic [KEY_W-1:0]   shadow, key_d;
  logic               key_valid_d, err_d;
  logic               sh_clr, sh_wr;
  logic               in_ready_q;
  logic               xfer_c, par_ok_c;

  assign bus.in_ready = in_ready_q;
  assign xfer_c       = (state_q == LOAD) && bus.in_valid && in_ready_q;

`ifdef OBF_KEY_PARITY_EN
  assign par_ok_c = ~^{bus.in_data, bus.in_parity};
`else
  logic unused_parity;
  assign unused_parity = bus.in_parity;
  assign par_ok_c      = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: abort beats a final transfer or a commit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        if (cfg_start) state_d = LOAD;
      LOAD: begin
        if (cfg_abort)                  state_d = IDLE;
        else if (xfer_c && !par_ok_c)   state_d = IDLE;
        else if (xfer_c && (cnt_q == LAST_IDX)) state_d = WAIT_COMMIT;
      end
      WAIT_COMMIT: begin
        if (cfg_abort)       state_d = IDLE;
        else if (commit_req) state_d = lock_req ? LOCKED : IDLE;
      end
      LOCKED:      state_d = LOCKED;
      default:     state_d = IDLE;
    endcase
  end

  // Datapath controls and next values of the registered outputs.
  always_comb begin
    sh_clr      = 1'b0;
    sh_wr       = 1'b0;
    cnt_d       = cnt_q;
    key_d       = key_out;
    key_valid_d = key_valid;
    err_d       = err;
    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          sh_clr = 1'b1;
          cnt_d  = '0;
          err_d  = 1'b0;
        end
      end
      LOAD: begin
        if (cfg_abort) begin
          sh_clr = 1'b1;
        end else if (xfer_c) begin
          if (!par_ok_c) begin
            sh_clr = 1'b1;
            err_d  = 1'b1;
          end else begin
            sh_wr = 1'b1;
            cnt_d = (cnt_q == LAST_IDX) ? '0 : cnt_q + IDX_W'(1);
          end
        end
      end
      WAIT_COMMIT: begin
        if (cfg_abort) begin
          sh_clr = 1'b1;
        end else if (commit_req) begin
          key_d       = shadow;
          key_valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      key_out    <= '0;
      key_valid  <= 1'b0;
      err        <= 1'b0;
      in_ready_q <= 1'b0;
      busy       <= 1'b0;
      locked     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      key_out    <= key_d;
      key_valid  <= key_valid_d;
      err        <= err_d;
      in_ready_q <= (state_d == LOAD);
      busy       <= (state_d == LOAD) || (state_d == WAIT_COMMIT);
      locked     <= (state_d == LOCKED);
    end
  end

  obf_key_shadow #(
    .KEY_W  (KEY_W),
    .WORD_W (WORD_W),
    .IDX_W  (IDX_W)
  ) u_shadow (
    .clk     (clk),
    .rst     (rst),
    .clr     (sh_clr),
    .wr_en   (sh_wr),
    .wr_idx  (cnt_q),
    .wr_data (bus.in_data),
    .shadow  (shadow)
  );

endmodule

// File: tb/tb_obf_key_cfg_ctrl.sv
// Self-checking bench for obf_key_cfg_ctrl against a word-concatenation key model.
module tb_obf_key_cfg_ctrl;

  localparam int unsigned NUM_CELLS = 5;
  localparam int unsigned WORD_W    = 4;
  localparam int unsigned KEY_W     = 2 * NUM_CELLS;

  logic             clk = 1'b0;
  logic             rst, cfg_start, cfg_abort, commit_req, lock_req;
  logic [KEY_W-1:0] key_out;
  logic             key_valid, busy, locked, err;

  int checks = 0;
  int errors = 0;

  logic [KEY_W-1:0] m_key;
  logic             m_valid;

  obf_key_cfg_ctrl_if #(.WORD_W(WORD_W)) bus ();

  obf_key_cfg_ctrl #(.NUM_CELLS(NUM_CELLS), .WORD_W(WORD_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_start  (cfg_start),
    .cfg_abort  (cfg_abort),
    .commit_req (commit_req),
    .lock_req   (lock_req),
    .bus        (bus),
    .key_out    (key_out),
    .key_valid  (key_valid),
    .busy       (busy),
    .locked     (locked),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Key = words concatenated LSW first, cut to KEY_W bits.
  function automatic logic [KEY_W-1:0] pack_key(input logic [3:0] w0, input logic [3:0] w1,
                                                input logic [3:0] w2);
    logic [11:0] full;
    full = {w2, w1, w0};
    return full[KEY_W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] d, input logic p, input logic ab);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL ready_timeout in_ready=%b expected 1 within 20 cycles", bus.in_ready);
    end
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_parity = p;
    cfg_abort     = ab;
    tick();
    bus.in_valid  = 1'b0;
    cfg_abort     = 1'b0;
  endtask

  task automatic load_key(input logic [3:0] w0, input logic [3:0] w1, input logic [3:0] w2);
    start_load();
    send_word(w0, ^w0, 1'b0);
    send_word(w1, ^w1, 1'b0);
    send_word(w2, ^w2, 1'b0);
  endtask

  task automatic do_commit(input logic lk);
    commit_req = 1'b1;
    lock_req   = lk;
    tick();
    commit_req = 1'b0;
    lock_req   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    m_key = '0;
    m_valid = 1'b0;
    checks++;
    if ({key_out, key_valid, bus.in_ready, busy, locked, err} !== '0) begin
      errors++;
      $display("FAIL reset_values got key=%h kv=%b rdy=%b busy=%b lk=%b err=%b expected all 0",
               key_out, key_valid, bus.in_ready, busy, locked, err);
    end
  endtask

  task automatic test_load_commit();
    logic [3:0] w[3];
    load_key(4'hA, 4'h5, 4'h3);
    checks++;
    if ({busy, bus.in_ready, key_out} !== {2'b10, m_key}) begin
      errors++;
      $display("FAIL wait_commit got busy=%b rdy=%b key=%h expected busy=1 rdy=0 key=%h",
               busy, bus.in_ready, key_out, m_key);
    end
    do_commit(1'b0);
    m_key = pack_key(4'hA, 4'h5, 4'h3);
    m_valid = 1'b1;
    checks++;
    if ({key_out, key_valid, busy, locked} !== {m_key, 3'b100} || m_key !== 10'h35A) begin
      errors++;
      $display("FAIL commit_35a got key=%h kv=%b busy=%b lk=%b expected key=35a kv=1 busy=0 lk=0",
               key_out, key_valid, busy, locked);
    end
    for (int it = 0; it < 6; it++) begin
      for (int k = 0; k < 3; k++) w[k] = 4'($urandom_range(0, 15));
      load_key(w[0], w[1], w[2]);
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) tick();
      checks++;
      if ({key_out, key_valid, busy} !== {m_key, m_valid, 1'b1}) begin
        errors++;
        $display("FAIL reload_holds_key got key=%h kv=%b busy=%b expected key=%h kv=%b busy=1",
                 key_out, key_valid, busy, m_key, m_valid);
      end
      do_commit(1'b0);
      m_key = pack_key(w[0], w[1], w[2]);
      checks++;
      if ({key_out, key_valid, busy} !== {m_key, 2'b10}) begin
        errors++;
        $display("FAIL random_commit got key=%h kv=%b busy=%b expected key=%h kv=1 busy=0",
                 key_out, key_valid, busy, m_key);
      end
    end
  endtask

  task automatic test_abort();
    start_load();
    send_word(4'hF, 1'b0, 1'b0);
    send_word(4'hF, 1'b0, 1'b0);
    send_word(4'hF, 1'b0, 1'b1);
    checks++;
    if ({key_out, key_valid, busy, bus.in_ready} !== {m_key, m_valid, 2'b00}) begin
      errors++;
      $display("FAIL abort_last_word got key=%h kv=%b busy=%b rdy=%b expected key=%h kv=%b busy=0 rdy=0",
               key_out, key_valid, busy, bus.in_ready, m_key, m_valid);
    end
    do_commit(1'b0);
    checks++;
    if ({key_out, busy} !== {m_key, 1'b0}) begin
      errors++;
      $display("FAIL idle_commit_ignored got key=%h busy=%b expected key=%h busy=0", key_out, busy, m_key);
    end
    load_key(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    cfg_abort = 1'b1;
    do_commit(1'b1);
    cfg_abort = 1'b0;
    checks++;
    if ({key_out, key_valid, busy, locked} !== {m_key, m_valid, 2'b00}) begin
      errors++;
      $display("FAIL abort_vs_commit got key=%h kv=%b busy=%b lk=%b expected key=%h kv=%b busy=0 lk=0",
               key_out, key_valid, busy, locked, m_key, m_valid);
    end
  endtask

  task automatic test_valid_gaps();
    logic [3:0] acc[3];
    int         nx = 0;
    logic [3:0] d;
    start_load();
    for (int c = 0; c < 18; c++) begin
      bus.in_valid  = (c % 3 == 0);
      d             = 4'($urandom_range(0, 15));
      bus.in_data   = d;
      bus.in_parity = ^d;
      if (bus.in_valid && bus.in_ready === 1'b1) begin
        if (nx < 3) acc[nx] = d;
        nx++;
      end
      tick();
      if (bus.in_valid && nx == 3 && c % 3 == 0 && acc[2] === d) begin
        checks++;
        if ({busy, bus.in_ready} !== 2'b10) begin
          errors++;
          $display("FAIL gap_third_xfer got busy=%b rdy=%b expected busy=1 rdy=0", busy, bus.in_ready);
        end
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    if (nx != 3) begin
      errors++;
      $display("FAIL gap_xfer_count got %0d expected 3", nx);
    end
    do_commit(1'b0);
    m_key = pack_key(acc[0], acc[1], acc[2]);
    checks++;
    if ({key_out, key_valid, busy} !== {m_key, 2'b10}) begin
      errors++;
      $display("FAIL gap_commit got key=%h kv=%b busy=%b expected key=%h kv=1 busy=0",
               key_out, key_valid, busy, m_key);
    end
  endtask

  task automatic test_parity();
`ifdef OBF_KEY_PARITY_EN
    start_load();
    send_word(4'h1, 1'b0, 1'b0);
    checks++;
    if ({err, busy, bus.in_ready, key_out} !== {3'b100, m_key}) begin
      errors++;
      $display("FAIL parity_err got err=%b busy=%b rdy=%b key=%h expected err=1 busy=0 rdy=0 key=%h",
               err, busy, bus.in_ready, key_out, m_key);
    end
    start_load();
    checks++;
    if ({err, busy, bus.in_ready} !== 3'b011) begin
      errors++;
      $display("FAIL parity_clear got err=%b busy=%b rdy=%b expected err=0 busy=1 rdy=1",
               err, busy, bus.in_ready);
    end
    send_word(4'h6, 1'b0, 1'b0);
    send_word(4'h7, 1'b0, 1'b0);
    checks++;
    if ({err, busy, key_out} !== {2'b10, m_key}) begin
      errors++;
      $display("FAIL parity_err_second got err=%b busy=%b key=%h expected err=1 busy=0 key=%h",
               err, busy, key_out, m_key);
    end
`else
    logic [3:0] w[3];
    for (int k = 0; k < 3; k++) w[k] = 4'($urandom_range(0, 15));
    start_load();
    for (int k = 0; k < 3; k++) send_word(w[k], ~^w[k], 1'b0);
    do_commit(1'b0);
    m_key = pack_key(w[0], w[1], w[2]);
    checks++;
    if ({err, key_out, key_valid} !== {1'b0, m_key, 1'b1}) begin
      errors++;
      $display("FAIL parity_ignored got err=%b key=%h kv=%b expected err=0 key=%h kv=1",
               err, key_out, key_valid, m_key);
    end
`endif
  endtask

  task automatic test_lock();
    load_key(4'hA, 4'h5, 4'h3);
    do_commit(1'b1);
    m_key = pack_key(4'hA, 4'h5, 4'h3);
    checks++;
    if ({key_out, key_valid, locked, busy} !== {m_key, 3'b110}) begin
      errors++;
      $display("FAIL lock_enter got key=%h kv=%b lk=%b busy=%b expected key=%h kv=1 lk=1 busy=0",
               key_out, key_valid, locked, busy, m_key);
    end
    for (int c = 0; c < 10; c++) begin
      cfg_start     = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      cfg_abort     = 1'($urandom_range(0, 1));
      commit_req    = 1'($urandom_range(0, 1));
      lock_req      = 1'($urandom_range(0, 1));
      bus.in_valid  = 1'b1;
      bus.in_data   = 4'($urandom_range(0, 15));
      bus.in_parity = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if ({key_out, locked, bus.in_ready, busy} !== {m_key, 3'b100}) begin
        errors++;
        $display("FAIL locked_frozen got key=%h lk=%b rdy=%b busy=%b expected key=%h lk=1 rdy=0 busy=0",
                 key_out, locked, bus.in_ready, busy, m_key);
      end
    end
    {cfg_start, cfg_abort, commit_req, lock_req, bus.in_valid} = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_key = '0;
    m_valid = 1'b0;
    checks++;
    if ({key_out, key_valid, locked, busy, err} !== '0) begin
      errors++;
      $display("FAIL lock_reset got key=%h kv=%b lk=%b busy=%b err=%b expected all 0",
               key_out, key_valid, locked, busy, err);
    end
  endtask

  task automatic test_rst_midload();
    load_key(4'h9, 4'h9, 4'h3);
    do_commit(1'b0);
    start_load();
    send_word(4'h4, 1'b1, 1'b0);
    send_word(4'h2, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({key_out, key_valid, bus.in_ready, busy, locked, err} !== '0) begin
      errors++;
      $display("FAIL rst_midload got key=%h kv=%b rdy=%b busy=%b lk=%b err=%b expected all 0",
               key_out, key_valid, bus.in_ready, busy, locked, err);
    end
    load_key(4'h0, 4'h0, 4'h1);
    do_commit(1'b0);
    m_key = pack_key(4'h0, 4'h0, 4'h1);
    checks++;
    if ({key_out, key_valid} !== {m_key, 1'b1} || m_key !== 10'h100) begin
      errors++;
      $display("FAIL reload_100 got key=%h kv=%b expected key=100 kv=1", key_out, key_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    {cfg_start, cfg_abort, commit_req, lock_req} = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_parity = 1'b0;
    test_reset();
    test_load_commit();
    test_abort();
    test_valid_gaps();
    test_parity();
    test_rst_midload();
    test_lock();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/obf_key_cfg_ctrl.md
Name: obf_key_cfg_ctrl

Overview:
Configuration controller for camouflaged-gate key inputs. Each camouflaged cell takes 2 select bits, {D_2i, D_2i+1}:
- 00 = pass
- 01 = invert
- 10 = force 1
- 11 = force 0

The block receives the key as words over a valid/ready stream and stages it in a shadow register. On commit it applies the whole key atomically to the obfuscated netlist's D_* inputs. It can then lock the key against further change until reset.

Parameters:
NUM_CELLS, 5, number of camouflaged cells; key width KEY_W = 2*NUM_CELLS (default 10).
WORD_W, 4, input word width; words per key NWORDS = ceil(KEY_W/WORD_W) (default 3).

Ports:
clk  input  1  clock.
rst  input  1  synchronous active-high reset.
cfg_start  input  1  begin a key load (pulse).
cfg_abort  input  1  discard the load in progress.
in_valid  input  1  word-stream valid.
in_ready  output  1  word-stream ready.
in_data  input  WORD_W  key word, least significant word first.
in_parity  input  1  even-parity bit for in_data; used only under OBF_KEY_PARITY_EN.
commit_req  input  1  apply the shadow key.
lock_req  input  1  sampled together with commit_req; lock after applying.
key_out  output  KEY_W  drives D_0..D_{KEY_W-1}; bit i = D_i.
key_valid  output  1  a committed key is applied.
busy  output  1  state is LOAD or WAIT_COMMIT.
locked  output  1  state is LOCKED.
err  output  1  sticky error flag.

Behaviour:
- Reset values: key_out=0 (all cells pass), key_valid=0, in_ready=0, busy=0, locked=0, err=0; state IDLE; word counter 0; shadow 0.
- IDLE:
  - cfg_start -> LOAD next cycle; shadow cleared, counter=0.
  - commit_req ignored.
- LOAD:
  - in_ready=1 (registered, asserted from the first LOAD cycle).
  - Transfer on in_valid & in_ready: shadow[cnt*WORD_W +: WORD_W] <= in_data. Bits at index >= KEY_W are dropped. cnt increments.
  - Transfer with cnt==NWORDS-1 -> WAIT_COMMIT; in_ready deasserts the next cycle.
  - cfg_start is ignored.
- WAIT_COMMIT:
  - commit_req -> key_out<=shadow and key_valid<=1 on the next edge (1-cycle latency).
  - Next state is LOCKED if lock_req=1 in the same cycle, else IDLE.
- LOCKED:
  - All inputs except rst are ignored; key_out frozen; in_ready=0.
  - Only rst exits LOCKED.
- Abort:
  - cfg_abort in LOAD or WAIT_COMMIT -> IDLE; shadow discarded; key_out and key_valid unchanged.
  - Abort wins over a simultaneous final transfer or commit.
- A re-load after a commit keeps the old key_out applied until the next commit. No glitch or partial key ever appears on key_out.
- err is set only by the parity feature; it is cleared by rst or by cfg_start.
- rst mid-load returns all outputs to their reset values, including key_out=0.

Optional Feature:
OBF_KEY_PARITY_EN:
- Defined:
  - Each transfer checks ^{in_data,in_parity}==0.
  - On mismatch: the word is not written, err<=1, state -> IDLE, shadow discarded, key_out unchanged.
- Undefined: in_parity is ignored and err stays 0.

Decomposition:
Package obf_key_pkg holds:
- cell-mode enum: CELL_PASS=2'b00, CELL_INV=2'b01, CELL_ONE=2'b10, CELL_ZERO=2'b11;
- state enum: IDLE, LOAD, WAIT_COMMIT, LOCKED;
- function nwords(key_w, word_w).

One sub-module, obf_key_shadow: word-addressed shadow register with clear, indexed write and truncation of the top word.

Test Plan:
1. Load 4'hA, 4'h5, 4'h3 with in_valid held, then commit_req -> key_out=10'h35A one cycle after commit; key_valid=1; state IDLE.
2. Repeat case 1 with lock_req=1 at commit, then cfg_start plus new words -> locked=1, in_ready stays 0, key_out remains 10'h35A until rst; after rst key_out=0.
3. Load 4'hF, 4'hF, then cfg_abort asserted together with the third word -> IDLE; key_out unchanged from its prior value; busy=0.
4. Word stream with in_valid gaps (valid for 1 cycle, low for 2 cycles, repeated) -> exactly 3 transfers; WAIT_COMMIT reached after the third transfer.
5. Under OBF_KEY_PARITY_EN, send in_data=4'h1 with in_parity=0 -> err=1, return to IDLE, key_out unchanged; the next cfg_start clears err.
6. rst asserted while in LOAD after 2 words -> all outputs at reset values the next cycle; a subsequent full load and commit of 4'h0, 4'h0, 4'h1 gives key_out=10'h100.
